// File: rtl/transmissao_matriz_serial.sv
// -----------------------------------------------------------------------------
// transmissao_matriz_serial
// Scans a LINHAS x COLUNAS pixel matrix held in an external synchronous-read
// memory (row-major) and sends every pixel as one UART character, optionally
// followed by a terminator character.
// Frame: start 0, 8 data bits LSB first, optional parity, stop 1.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   iniciar      start request, sampled only while idle (OCIOSO)
//   dados_pixel  pixel from memory, valid one cycle after the address changes
//   addr_linha   row address to the memory
//   addr_coluna  column address to the memory
//   saida_serial UART TX line, idle high, registered
//   ocupado      high while a frame is in progress (through the fim cycle)
//   fim          one-cycle pulse when the frame completes
//   db_estado    current state code for the 7-segment debug display
// -----------------------------------------------------------------------------
module transmissao_matriz_serial #(
   parameter int         LINHAS     = 3,
   parameter int         COLUNAS    = 3,
   parameter int         LARG_PIXEL = 3,
   parameter int         DIV_BAUD   = 5208,
   parameter int         PARIDADE   = 0,
   parameter int         MODO_ASCII = 0,
   parameter logic [7:0] TERMINADOR = 8'h0A,
   parameter int         ENVIA_TERM = 1,
   localparam int        LARG_LINHA  = (LINHAS  > 32'sd1) ? $clog2(LINHAS)  : 32'sd1,
   localparam int        LARG_COLUNA = (COLUNAS > 32'sd1) ? $clog2(COLUNAS) : 32'sd1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   iniciar,
   input  logic [LARG_PIXEL-1:0]  dados_pixel,
   output logic [LARG_LINHA-1:0]  addr_linha,
   output logic [LARG_COLUNA-1:0] addr_coluna,
   output logic                   saida_serial,
   output logic                   ocupado,
   output logic                   fim,
   output logic [3:0]             db_estado
);

   localparam int NBITS     = (PARIDADE != 32'sd0) ? 32'sd11 : 32'sd10;
   localparam int LARG_BAUD = $clog2(DIV_BAUD);
   localparam int LARG_BIT  = $clog2(NBITS);

   localparam logic [LARG_BAUD-1:0]   ULT_BAUD   = LARG_BAUD'(DIV_BAUD - 32'sd1);
   localparam logic [LARG_BAUD-1:0]   UM_BAUD    = LARG_BAUD'(32'sd1);
   localparam logic [LARG_BAUD-1:0]   ZERO_BAUD  = LARG_BAUD'(32'sd0);
   localparam logic [LARG_BIT-1:0]    ULT_BIT    = LARG_BIT'(NBITS - 32'sd1);
   localparam logic [LARG_BIT-1:0]    UM_BIT     = LARG_BIT'(32'sd1);
   localparam logic [LARG_BIT-1:0]    ZERO_BIT   = LARG_BIT'(32'sd0);
   localparam logic [LARG_LINHA-1:0]  ULT_LINHA  = LARG_LINHA'(LINHAS - 32'sd1);
   localparam logic [LARG_LINHA-1:0]  UM_LINHA   = LARG_LINHA'(32'sd1);
   localparam logic [LARG_LINHA-1:0]  ZERO_LINHA = LARG_LINHA'(32'sd0);
   localparam logic [LARG_COLUNA-1:0] ULT_COL    = LARG_COLUNA'(COLUNAS - 32'sd1);
   localparam logic [LARG_COLUNA-1:0] UM_COL     = LARG_COLUNA'(32'sd1);
   localparam logic [LARG_COLUNA-1:0] ZERO_COL   = LARG_COLUNA'(32'sd0);
   localparam logic [10:0]            QUADRO_REP = 11'h7FF;

   typedef enum logic [3:0] {
      OCIOSO    = 4'd0,
      LE        = 4'd1,
      CARREGA   = 4'd2,
      TRANSMITE = 4'd3,
      TERM      = 4'd4,
      FIM       = 4'd5
   } estado_t;

   estado_t                estado_r;
   logic [10:0]            quadro_r;
   logic [LARG_BAUD-1:0]   cont_baud_r;
   logic [LARG_BIT-1:0]    ind_bit_r;
   logic [LARG_LINHA-1:0]  linha_r;
   logic [LARG_COLUNA-1:0] coluna_r;
   logic                   saida_r;
   logic                   ocupado_r;
   logic                   fim_r;
   logic                   ultimo_pixel_s;

   // Pixel to character byte: zero-extended, or offset from ASCII '0' (wraps mod 256).
   function automatic logic [7:0] codifica(input logic [LARG_PIXEL-1:0] px);
      logic [7:0] base;
      base = 8'(px);
      if (MODO_ASCII != 32'sd0) begin
         codifica = 8'h30 + base;
      end else begin
         codifica = base;
      end
   endfunction

   // Full character frame, LSB sent first. Without parity bit 9 is the stop
   // bit and bit 10 is never reached.
   function automatic logic [10:0] monta_quadro(input logic [7:0] dado);
      logic bit_par;
      case (PARIDADE)
         32'sd1:  bit_par = ^dado;
         32'sd2:  bit_par = ~^dado;
         default: bit_par = 1'b1;
      endcase
      monta_quadro = {1'b1, bit_par, dado, 1'b0};
   endfunction

   assign ultimo_pixel_s = (linha_r == ULT_LINHA) && (coluna_r == ULT_COL);

   // Frame sequencer: state, bit timing, addresses and all registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_r    <= OCIOSO;
         quadro_r    <= QUADRO_REP;
         cont_baud_r <= ZERO_BAUD;
         ind_bit_r   <= ZERO_BIT;
         linha_r     <= ZERO_LINHA;
         coluna_r    <= ZERO_COL;
         saida_r     <= 1'b1;
         ocupado_r   <= 1'b0;
         fim_r       <= 1'b0;
      end else begin
         fim_r <= 1'b0;
         case (estado_r)
            OCIOSO: begin
               saida_r <= 1'b1;
               if (iniciar) begin
                  estado_r  <= LE;
                  ocupado_r <= 1'b1;
               end else begin
                  ocupado_r <= 1'b0;
               end
            end
            LE: begin
               saida_r   <= 1'b1;
               ocupado_r <= 1'b1;
               estado_r  <= CARREGA;
            end
            CARREGA: begin
               saida_r     <= 1'b1;
               ocupado_r   <= 1'b1;
               quadro_r    <= monta_quadro(codifica(dados_pixel));
               cont_baud_r <= ZERO_BAUD;
               ind_bit_r   <= ZERO_BIT;
               estado_r    <= TRANSMITE;
            end
            TRANSMITE, TERM: begin
               ocupado_r <= 1'b1;
               // Output lags the shifter by one cycle, so each bit still spans DIV_BAUD cycles.
               saida_r   <= quadro_r[0];
               if (cont_baud_r == ULT_BAUD) begin
                  cont_baud_r <= ZERO_BAUD;
                  quadro_r    <= {1'b1, quadro_r[10:1]};
                  if (ind_bit_r == ULT_BIT) begin
                     ind_bit_r <= ZERO_BIT;
                     if (estado_r == TERM) begin
                        estado_r <= FIM;
                     end else if (ultimo_pixel_s) begin
                        if (ENVIA_TERM != 32'sd0) begin
                           // Terminator follows immediately; no memory read needed.
                           quadro_r <= monta_quadro(TERMINADOR);
                           estado_r <= TERM;
                        end else begin
                           estado_r <= FIM;
                        end
                     end else begin
                        if (coluna_r == ULT_COL) begin
                           coluna_r <= ZERO_COL;
                           linha_r  <= linha_r + UM_LINHA;
                        end else begin
                           coluna_r <= coluna_r + UM_COL;
                        end
                        estado_r <= LE;
                     end
                  end else begin
                     ind_bit_r <= ind_bit_r + UM_BIT;
                  end
               end else begin
                  cont_baud_r <= cont_baud_r + UM_BAUD;
               end
            end
            FIM: begin
               saida_r   <= 1'b1;
               ocupado_r <= 1'b1;
               fim_r     <= 1'b1;
               linha_r   <= ZERO_LINHA;
               coluna_r  <= ZERO_COL;
               estado_r  <= OCIOSO;
            end
            default: begin
               saida_r   <= 1'b1;
               ocupado_r <= 1'b0;
               estado_r  <= OCIOSO;
            end
         endcase
      end
   end

   assign addr_linha   = linha_r;
   assign addr_coluna  = coluna_r;
   assign saida_serial = saida_r;
   assign ocupado      = ocupado_r;
   assign fim          = fim_r;
   assign db_estado    = estado_r;

endmodule

// File: tb/tb_transmissao_matriz_serial.sv
// -----------------------------------------------------------------------------
// tb_transmissao_matriz_serial
// Directed bench for transmissao_matriz_serial. Five instances with different
// parameter sets share one clock; a selector routes the line and fim of the
// instance under test to a bit-level UART receiver (DIV_BAUD = 4 everywhere).
// -----------------------------------------------------------------------------
module tb_transmissao_matriz_serial;

   logic clk;
   int   ciclo;
   int   total;
   int   bad;
   int   sel;

   // instance a: defaults, 3x3, with terminator
   logic rst_a, ini_a, ser_a, oc_a, fim_a;
   logic [2:0] pix_a;
   logic [1:0] al_a, ac_a;
   logic [3:0] db_a;
   // instance b/c: 1x1, ASCII, even/odd parity, no terminator
   logic rst_b, ini_b, ser_b, oc_b, fim_b;
   logic [2:0] pix_b;
   logic [0:0] al_b, ac_b;
   logic [3:0] db_b;
   logic rst_c, ini_c, ser_c, oc_c, fim_c;
   logic [2:0] pix_c;
   logic [0:0] al_c, ac_c;
   logic [3:0] db_c;
   // instance d: 2x5, no terminator
   logic rst_d, ini_d, ser_d, oc_d, fim_d;
   logic [3:0] pix_d;
   logic [0:0] al_d;
   logic [2:0] ac_d;
   logic [3:0] db_d;
   // instance e: 1x1, 8-bit pixel, with terminator
   logic rst_e, ini_e, ser_e, oc_e, fim_e;
   logic [7:0] pix_e;
   logic [0:0] al_e, ac_e;
   logic [3:0] db_e;

   logic mon, fim_mon;

   transmissao_matriz_serial #(.DIV_BAUD(4)) u_a (
      .clock(clk), .reset(rst_a), .iniciar(ini_a), .dados_pixel(pix_a),
      .addr_linha(al_a), .addr_coluna(ac_a), .saida_serial(ser_a),
      .ocupado(oc_a), .fim(fim_a), .db_estado(db_a));

   transmissao_matriz_serial #(.LINHAS(1), .COLUNAS(1), .DIV_BAUD(4), .PARIDADE(1),
      .MODO_ASCII(1), .ENVIA_TERM(0)) u_b (
      .clock(clk), .reset(rst_b), .iniciar(ini_b), .dados_pixel(pix_b),
      .addr_linha(al_b), .addr_coluna(ac_b), .saida_serial(ser_b),
      .ocupado(oc_b), .fim(fim_b), .db_estado(db_b));

   transmissao_matriz_serial #(.LINHAS(1), .COLUNAS(1), .DIV_BAUD(4), .PARIDADE(2),
      .MODO_ASCII(1), .ENVIA_TERM(0)) u_c (
      .clock(clk), .reset(rst_c), .iniciar(ini_c), .dados_pixel(pix_c),
      .addr_linha(al_c), .addr_coluna(ac_c), .saida_serial(ser_c),
      .ocupado(oc_c), .fim(fim_c), .db_estado(db_c));

   transmissao_matriz_serial #(.LINHAS(2), .COLUNAS(5), .LARG_PIXEL(4), .DIV_BAUD(4),
      .ENVIA_TERM(0)) u_d (
      .clock(clk), .reset(rst_d), .iniciar(ini_d), .dados_pixel(pix_d),
      .addr_linha(al_d), .addr_coluna(ac_d), .saida_serial(ser_d),
      .ocupado(oc_d), .fim(fim_d), .db_estado(db_d));

   transmissao_matriz_serial #(.LINHAS(1), .COLUNAS(1), .LARG_PIXEL(8), .DIV_BAUD(4)) u_e (
      .clock(clk), .reset(rst_e), .iniciar(ini_e), .dados_pixel(pix_e),
      .addr_linha(al_e), .addr_coluna(ac_e), .saida_serial(ser_e),
      .ocupado(oc_e), .fim(fim_e), .db_estado(db_e));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial ciclo = 0;
   always @(posedge clk) ciclo <= ciclo + 1;

   // synchronous-read memories
   always @(posedge clk) begin
      pix_a <= 3'((int'(al_a) * 3 + int'(ac_a)) % 8);
      pix_d <= 4'(int'(al_d) * 5 + int'(ac_d));
   end
   assign pix_b = 3'd3;
   assign pix_c = 3'd3;
   assign pix_e = 8'hA5;

   always_comb begin
      case (sel)
         0:       begin mon = ser_a; fim_mon = fim_a; end
         1:       begin mon = ser_b; fim_mon = fim_b; end
         2:       begin mon = ser_c; fim_mon = fim_c; end
         3:       begin mon = ser_d; fim_mon = fim_d; end
         default: begin mon = ser_e; fim_mon = fim_e; end
      endcase
   end

   task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      total++;
      if (obs !== esp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
      end
   endtask

   // Must be called at a negedge; returns at the negedge of the first cycle after the stop bit.
   task automatic recebe(input int nbits, output logic [7:0] dado, output logic par, output int ini);
      logic [10:0] bits;
      int n;
      n = 0;
      bits = 11'h000;
      while (mon !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      confere("start_timeout", 32'(n < 300), 32'd1);
      ini = ciclo;
      for (int k = 0; k < nbits; k++) begin
         repeat (2) @(negedge clk);
         bits[k] = mon;
         repeat (2) @(negedge clk);
      end
      confere("stop_bit", 32'(bits[nbits-1]), 32'd1);
      dado = bits[8:1];
      par  = bits[9];
   endtask

   task automatic espera_fim(output int f);
      int n;
      n = 0;
      while (fim_mon !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      confere("fim_timeout", 32'(n < 500), 32'd1);
      f = ciclo;
   endtask

   // Full 3x3 frame from instance a: 9 pixels plus terminator.
   task automatic quadro_a(input int t_ini, input logic oc_prox, output int fc);
      logic [7:0] d;
      logic p;
      int s, s0, fim_ant;
      s0 = 0;
      fim_ant = 0;
      for (int i = 0; i < 10; i++) begin
         recebe(10, d, p, s);
         confere($sformatf("a_char%0d", i), 32'(d), (i < 9) ? 32'(i % 8) : 32'h0A);
         if (i == 0) begin
            s0 = s;
            confere("a_latencia", s, t_ini + 3);
         end else begin
            confere($sformatf("a_gap%0d", i), s - fim_ant, (i < 9) ? 32'd2 : 32'd0);
         end
         fim_ant = s + 40;
      end
      espera_fim(fc);
      confere("a_fim_pos", fc, fim_ant);
      confere("a_N", fc - s0 + 1, 32'd417);
      confere("a_oc_no_fim", 32'(oc_a), 32'd1);
      @(negedge clk);
      confere("a_fim_pulso", 32'(fim_a), 32'd0);
      confere("a_oc_apos", 32'(oc_a), 32'(oc_prox));
   endtask

   initial begin
      logic [7:0] d;
      logic p;
      int s, s0, f, t, baixos;
      total = 0;
      bad = 0;
      sel = 0;
      {rst_a, rst_b, rst_c, rst_d, rst_e} = 5'b11111;
      {ini_a, ini_b, ini_c, ini_d, ini_e} = 5'b00000;
      repeat (2) @(negedge clk);
      {rst_a, rst_b, rst_c, rst_d, rst_e} = 5'b00000;

      // reset state
      confere("rst_saida", 32'(ser_a), 32'd1);
      confere("rst_ocupado", 32'(oc_a), 32'd0);
      confere("rst_fim", 32'(fim_a), 32'd0);
      confere("rst_addr", {30'd0, al_a} | {30'd0, ac_a}, 32'd0);
      confere("rst_db", 32'(db_a), 32'd0);

      // test 1: default frame
      ini_a = 1'b1;
      @(negedge clk);
      ini_a = 1'b0;
      t = ciclo;
      confere("a_db_le", 32'(db_a), 32'd1);
      confere("a_oc_le", 32'(oc_a), 32'd1);
      @(negedge clk);
      confere("a_db_carrega", 32'(db_a), 32'd2);
      @(negedge clk);
      confere("a_db_transmite", 32'(db_a), 32'd3);
      quadro_a(t, 1'b0, f);

      // test 4: reset during data bit 3 of the second character
      ini_a = 1'b1;
      @(negedge clk);
      ini_a = 1'b0;
      recebe(10, d, p, s);
      repeat (2 + 17) @(negedge clk);
      confere("pre_rst_linha", 32'(ser_a), 32'd0);
      confere("pre_rst_coluna", 32'(ac_a), 32'd1);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      confere("mrst_saida", 32'(ser_a), 32'd1);
      confere("mrst_ocupado", 32'(oc_a), 32'd0);
      confere("mrst_addr", {30'd0, al_a} | {30'd0, ac_a}, 32'd0);
      confere("mrst_db", 32'(db_a), 32'd0);

      // restart from (0,0), with a re-pulse of iniciar while busy
      ini_a = 1'b1;
      @(negedge clk);
      ini_a = 1'b0;
      t = ciclo;
      fork
         begin
            repeat (100) @(negedge clk);
            ini_a = 1'b1;
            @(negedge clk);
            ini_a = 1'b0;
         end
      join_none
      quadro_a(t, 1'b0, f);
      baixos = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (ser_a === 1'b0) baixos++;
      end
      confere("a_sem_extra", baixos, 32'd0);

      // test 5: iniciar held high -> back-to-back frames
      ini_a = 1'b1;
      @(negedge clk);
      t = ciclo;
      quadro_a(t, 1'b1, f);
      recebe(10, d, p, s);
      confere("a2_char0", 32'(d), 32'd0);
      confere("a2_inicio", s, f + 4);
      ini_a = 1'b0;
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;

      // test 2: ASCII with even / odd parity
      sel = 1;
      ini_b = 1'b1;
      @(negedge clk);
      ini_b = 1'b0;
      recebe(11, d, p, s);
      confere("b_dado", 32'(d), 32'h33);
      confere("b_par_par", 32'(p), 32'd0);
      espera_fim(f);
      confere("b_fim_pos", f, s + 44);
      sel = 2;
      ini_c = 1'b1;
      @(negedge clk);
      ini_c = 1'b0;
      recebe(11, d, p, s);
      confere("c_dado", 32'(d), 32'h33);
      confere("c_par_impar", 32'(p), 32'd1);
      espera_fim(f);

      // test 3: 2x5 scan order, no terminator
      sel = 3;
      ini_d = 1'b1;
      @(negedge clk);
      ini_d = 1'b0;
      s0 = 0;
      t = 0;
      for (int i = 0; i < 10; i++) begin
         recebe(10, d, p, s);
         confere($sformatf("d_char%0d", i), 32'(d), 32'(i));
         if (i == 0) s0 = s;
         else confere($sformatf("d_gap%0d", i), s - t, 32'd2);
         t = s + 40;
      end
      espera_fim(f);
      confere("d_fim_pos", f, t);
      confere("d_N", f - s0 + 1, 32'd419);

      // test 6: single 8-bit pixel plus terminator
      sel = 4;
      ini_e = 1'b1;
      @(negedge clk);
      ini_e = 1'b0;
      recebe(10, d, p, s0);
      confere("e_dado", 32'(d), 32'hA5);
      recebe(10, d, p, s);
      confere("e_term", 32'(d), 32'h0A);
      confere("e_gap_term", s - (s0 + 40), 32'd0);
      espera_fim(f);
      confere("e_N", f - s0 + 1, 32'd81);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
